// File: rtl/write_decoder.sv
// One-hot register write decoder with registered copies and write counter.
// Define WRITE_DECODER_STATS_EN to build the saturating wr_count counter.
module write_decoder #(
  parameter bit MASK_X0 = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A,
  input  logic        WE,
  output logic [31:0] en,
  output logic [31:0] en_q,
  output logic        we_q,
  output logic [4:0]  addr_q,
  output logic [15:0] wr_count
);

  always_comb begin
    en = '0;
    if (WE) en[A] = 1'b1;
    if (MASK_X0) en[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      en_q <= en;
      we_q <= WE;
      if (WE) addr_q <= A;
    end
  end

`ifdef WRITE_DECODER_STATS_EN
  logic [15:0] cnt;

  // Masked x0 writes leave en zero, so they never count.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (|en && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

  assign wr_count = cnt;
`else
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_write_decoder.sv
// Directed testbench for write_decoder.
// Runs a plain instance and an x0-masked instance side by side.
module tb_write_decoder;

`ifdef WRITE_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  a;
  logic        we;
  logic [31:0] en, en_q, en_m, en_q_m;
  logic        we_q, we_q_m;
  logic [4:0]  addr_q, addr_q_m;
  logic [15:0] wr_count, wr_count_m;

  int pass_cnt = 0;
  int total = 0;

  write_decoder #(.MASK_X0(1'b0)) dut (
    .clk(clk), .reset(reset), .A(a), .WE(we),
    .en(en), .en_q(en_q), .we_q(we_q),
    .addr_q(addr_q), .wr_count(wr_count)
  );

  write_decoder #(.MASK_X0(1'b1)) dut_m (
    .clk(clk), .reset(reset), .A(a), .WE(we),
    .en(en_m), .en_q(en_q_m), .we_q(we_q_m),
    .addr_q(addr_q_m), .wr_count(wr_count_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] cexp(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; we = 1'b1; a = 5'd3;
    edge_n(2);
    total++;
    if (en_q !== 32'h0) $display("FAIL rst_en_q got %h exp 0", en_q);
    else pass_cnt++;
    total++;
    if (we_q !== 1'b0) $display("FAIL rst_we_q got %b exp 0", we_q);
    else pass_cnt++;
    total++;
    if (addr_q !== 5'd0) $display("FAIL rst_addr_q got %0d exp 0", addr_q);
    else pass_cnt++;
    total++;
    if (wr_count !== 16'd0) $display("FAIL rst_cnt got %h exp 0", wr_count);
    else pass_cnt++;
    total++;
    if (wr_count_m !== 16'd0) $display("FAIL rst_cnt_m got %h exp 0", wr_count_m);
    else pass_cnt++;
  endtask

  // Sweep held in reset: en must still decode, registers stay clear.
  task automatic test_sweep_we1;
    logic [31:0] exp;
    reset = 1'b1; we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      #10;
      exp = 32'h1 << i;
      total++;
      if (en !== exp) $display("FAIL sweep1_en a=%0d got %h exp %h", i, en, exp);
      else pass_cnt++;
      exp = (i == 0) ? 32'h0 : 32'h1 << i;
      total++;
      if (en_m !== exp) $display("FAIL sweep1_en_m a=%0d got %h exp %h", i, en_m, exp);
      else pass_cnt++;
    end
    total++;
    if (en_q !== 32'h0) $display("FAIL sweep1_en_q got %h exp 0", en_q);
    else pass_cnt++;
  endtask

  task automatic test_sweep_we0;
    @(negedge clk);
    reset = 1'b0; we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      #1;
      total++;
      if (en !== 32'h0) $display("FAIL sweep0_en a=%0d got %h exp 0", i, en);
      else pass_cnt++;
    end
    edge_n(1);
    total++;
    if (en_q !== 32'h0) $display("FAIL sweep0_en_q got %h exp 0", en_q);
    else pass_cnt++;
    total++;
    if (we_q !== 1'b0) $display("FAIL sweep0_we_q got %b exp 0", we_q);
    else pass_cnt++;
    total++;
    if (wr_count !== 16'd0) $display("FAIL sweep0_cnt got %h exp 0", wr_count);
    else pass_cnt++;
  endtask

  task automatic test_single_write;
    @(negedge clk);
    reset = 1'b1; we = 1'b0;
    edge_n(2);
    @(negedge clk);
    reset = 1'b0; we = 1'b1; a = 5'd5;
    edge_n(1);
    total++;
    if (en_q !== 32'h20) $display("FAIL wr_en_q got %h exp 20", en_q);
    else pass_cnt++;
    total++;
    if (we_q !== 1'b1) $display("FAIL wr_we_q got %b exp 1", we_q);
    else pass_cnt++;
    total++;
    if (addr_q !== 5'd5) $display("FAIL wr_addr_q got %0d exp 5", addr_q);
    else pass_cnt++;
    total++;
    if (wr_count !== cexp(1)) $display("FAIL wr_cnt got %h exp %h", wr_count, cexp(1));
    else pass_cnt++;
    @(negedge clk);
    we = 1'b0; a = 5'd9;
    edge_n(1);
    total++;
    if (addr_q !== 5'd5) $display("FAIL hold_addr_q got %0d exp 5", addr_q);
    else pass_cnt++;
    total++;
    if (en_q !== 32'h0) $display("FAIL hold_en_q got %h exp 0", en_q);
    else pass_cnt++;
    total++;
    if (we_q !== 1'b0) $display("FAIL hold_we_q got %b exp 0", we_q);
    else pass_cnt++;
    total++;
    if (wr_count !== cexp(1)) $display("FAIL hold_cnt got %h exp %h", wr_count, cexp(1));
    else pass_cnt++;
  endtask

  task automatic test_reset_priority;
    @(negedge clk);
    reset = 1'b1; we = 1'b1; a = 5'd7;
    #1;
    total++;
    if (en !== 32'h80) $display("FAIL prio_en got %h exp 80", en);
    else pass_cnt++;
    edge_n(1);
    total++;
    if (en_q !== 32'h0) $display("FAIL prio_en_q got %h exp 0", en_q);
    else pass_cnt++;
    total++;
    if (addr_q !== 5'd0) $display("FAIL prio_addr_q got %0d exp 0", addr_q);
    else pass_cnt++;
    total++;
    if (wr_count !== 16'd0) $display("FAIL prio_cnt got %h exp 0", wr_count);
    else pass_cnt++;
  endtask

  task automatic test_mask_x0;
    @(negedge clk);
    reset = 1'b0; we = 1'b1; a = 5'd0;
    #1;
    total++;
    if (en_m !== 32'h0) $display("FAIL mask_en0 got %h exp 0", en_m);
    else pass_cnt++;
    total++;
    if (en !== 32'h1) $display("FAIL a0_en got %h exp 1", en);
    else pass_cnt++;
    edge_n(1);
    total++;
    if (wr_count_m !== 16'd0) $display("FAIL mask_cnt0 got %h exp 0", wr_count_m);
    else pass_cnt++;
    total++;
    if (en_q_m !== 32'h0) $display("FAIL mask_en_q0 got %h exp 0", en_q_m);
    else pass_cnt++;
    total++;
    if (wr_count !== cexp(1)) $display("FAIL a0_cnt got %h exp %h", wr_count, cexp(1));
    else pass_cnt++;
    @(negedge clk);
    a = 5'd1;
    #1;
    total++;
    if (en_m !== 32'h2) $display("FAIL mask_en1 got %h exp 2", en_m);
    else pass_cnt++;
    edge_n(1);
    total++;
    if (wr_count_m !== cexp(1)) $display("FAIL mask_cnt1 got %h exp %h", wr_count_m, cexp(1));
    else pass_cnt++;
    total++;
    if (en_q_m !== 32'h2) $display("FAIL mask_en_q1 got %h exp 2", en_q_m);
    else pass_cnt++;
    total++;
    if (addr_q_m !== 5'd1) $display("FAIL mask_addr_q got %0d exp 1", addr_q_m);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    reset = 1'b1; we = 1'b0;
    edge_n(1);
    @(negedge clk);
    reset = 1'b0; we = 1'b1; a = 5'd12;
    edge_n(3);
    total++;
    if (wr_count !== cexp(3)) $display("FAIL mid_cnt3 got %h exp %h", wr_count, cexp(3));
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    edge_n(1);
    total++;
    if (wr_count !== 16'd0) $display("FAIL mid_rst_cnt got %h exp 0", wr_count);
    else pass_cnt++;
    total++;
    if (addr_q !== 5'd0) $display("FAIL mid_rst_addr got %0d exp 0", addr_q);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0; a = 5'd31;
    #1;
    total++;
    if (en !== 32'h8000_0000) $display("FAIL a31_en got %h exp 80000000", en);
    else pass_cnt++;
    edge_n(2);
    total++;
    if (wr_count !== cexp(2)) $display("FAIL mid_cnt2 got %h exp %h", wr_count, cexp(2));
    else pass_cnt++;
    total++;
    if (en_q !== 32'h8000_0000) $display("FAIL a31_en_q got %h exp 80000000", en_q);
    else pass_cnt++;
  endtask

  task automatic test_saturation;
    @(negedge clk);
    reset = 1'b1; we = 1'b0;
    edge_n(1);
    @(negedge clk);
    reset = 1'b0; we = 1'b1; a = 5'd3;
    edge_n(65535);
    total++;
    if (wr_count !== cexp(65535)) $display("FAIL sat_top got %h exp %h", wr_count, cexp(65535));
    else pass_cnt++;
    edge_n(5);
    total++;
    if (wr_count !== cexp(65535)) $display("FAIL sat_hold got %h exp %h", wr_count, cexp(65535));
    else pass_cnt++;
    total++;
    if (wr_count_m !== cexp(65535)) $display("FAIL sat_m got %h exp %h", wr_count_m, cexp(65535));
    else pass_cnt++;
    @(negedge clk);
    we = 1'b0;
    edge_n(2);
    total++;
    if (wr_count !== cexp(65535)) $display("FAIL sat_idle got %h exp %h", wr_count, cexp(65535));
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    we = 1'b0;
    a = 5'd0;
    test_reset();
    test_sweep_we1();
    test_sweep_we0();
    test_single_write();
    test_reset_priority();
    test_mask_x0();
    test_mid_reset();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/write_decoder.md
WRITE_DECODER -- requirements
Module: write_decoder

Interface
REQ-001 Parameter MASK_X0, default 0: when 1, output bit 0 of every enable vector is forced low (register x0 never written).
REQ-002 Port clk, input, 1, single rising-edge clock for all registered outputs.
REQ-003 Port reset, input, 1, synchronous, active-high reset sampled on rising edge of clk.
REQ-004 Port A, input, 5, register/write address.
REQ-005 Port WE, input, 1, write enable.
REQ-006 Port en, output, 32, combinational one-hot write enable vector.
REQ-007 Port en_q, output, 32, en registered one cycle.
REQ-008 Port we_q, output, 1, WE registered one cycle.
REQ-009 Port addr_q, output, 5, A registered one cycle (captured only when WE=1).
REQ-010 Port wr_count, output, 16, saturating count of accepted writes.

Function
REQ-011 en SHALL equal (1 << A) when WE=1 and all-zero when WE=0; zero latency, purely combinational, independent of clk and reset.
REQ-012 With MASK_X0=1, en[0] SHALL be 0 for all inputs; all other bits per REQ-011.
REQ-013 en SHALL never have more than one bit set; A=31 with WE=1 SHALL give en=0x8000_0000, A=0 with WE=1 SHALL give 0x0000_0001 (MASK_X0=0).
REQ-014 When WE=0, en SHALL be zero regardless of A, including unknown A.
REQ-015 On each rising clk edge with reset=0: en_q <= en, we_q <= WE; addr_q <= A only if WE=1, else addr_q holds.
REQ-016 An accepted write is a cycle with en nonzero at the rising edge; wr_count SHALL increment by 1 per accepted write.
REQ-017 wr_count SHALL saturate at 0xFFFF and hold; no wrap-around.
REQ-018 With MASK_X0=1, a write to A=0 is not accepted and SHALL NOT increment wr_count.

Reset
REQ-019 When reset=1 at a rising edge: en_q=0, we_q=0, addr_q=0, wr_count=0 after that edge.
REQ-020 Reset SHALL take priority over a simultaneous write; the write in that cycle is not counted nor captured.
REQ-021 Reset SHALL NOT affect combinational en; en follows A/WE during reset.
REQ-022 Reset asserted mid-sequence SHALL clear registered state on the next edge; counting resumes from 0 after reset deasserts.

Configuration
REQ-023 Macro WRITE_DECODER_STATS_EN: when defined, wr_count logic per REQ-016..018 is compiled in.
REQ-024 When WRITE_DECODER_STATS_EN is not defined, wr_count SHALL be tied to constant 0 and no counter logic exists; all other behaviour is unchanged.

Verification
REQ-025 WE=1, A swept 0..31, check after 10 ns settle -> en == 2**A each step (MASK_X0=0), no clock needed.
REQ-026 WE=0, A swept 0..31 -> en == 0 every step; en_q == 0 and we_q == 0 after following edge.
REQ-027 Reset 2 cycles, then WE=1 A=5 for one edge -> en_q=0x0000_0020, we_q=1, addr_q=5, wr_count=1; then WE=0 A=9 -> addr_q stays 5, en_q=0.
REQ-028 WE=1 with reset=1 at same edge, A=7 -> en=0x0000_0080 combinationally, en_q=0, addr_q=0, wr_count=0 after edge.
REQ-029 STATS_EN defined, WE=1 for 65,540 edges -> wr_count=0xFFFF and holds; macro undefined -> wr_count=0 throughout.
REQ-030 MASK_X0=1, WE=1, A=0 -> en=0, wr_count unchanged; A=1 -> en=0x0000_0002, wr_count +1.
